// File: rtl/masked_chi5_plane_ctrl.sv
// masked_chi5_plane_ctrl: runs a two-share 25-bit Keccak plane row by row through one
// masked chi5 datapath, holding each row for LAT cycles of valid randomness.
module masked_chi5_plane_ctrl #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_share0,
    input  logic [24:0] in_share1,
    input  logic        rnd_valid,
    input  logic        rnd_bit,
    output logic        rnd_ready,
    output logic [4:0]  chi_share0_in,
    output logic [4:0]  chi_share1_in,
    output logic        chi_rand,
    input  logic [4:0]  chi_share0_out,
    input  logic [4:0]  chi_share1_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] out_share0,
    output logic [24:0] out_share1,
    output logic        busy
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [24:0]   sh0_q, sh0_d, sh1_q, sh1_d;
    logic [4:0]    base;

    assign base = {row_q, 2'b00} + {2'b00, row_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                row_d   = '0;
                cnt_d   = '0;
                sh0_d   = in_share0;
                sh1_d   = in_share1;
            end
            // a gap in randomness restarts the row's hold window
            RUN: if (!rnd_valid) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d             = '0;
                sh0_d[base +: 5]  = chi_share0_out;
                sh1_d[base +: 5]  = chi_share1_out;
                state_d           = (row_q == 3'd4) ? DONE : RUN;
                row_d             = (row_q == 3'd4) ? row_q : row_q + 1'b1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready      = state_q == IDLE;
        busy          = state_q != IDLE;
        rnd_ready     = state_q == RUN;
        out_valid     = state_q == DONE;
        chi_share0_in = (state_q == RUN) ? sh0_q[base +: 5] : '0;
        chi_share1_in = (state_q == RUN) ? sh1_q[base +: 5] : '0;
        chi_rand      = (state_q == RUN) & rnd_valid & rnd_bit;
        out_share0    = (state_q == DONE) ? sh0_q : '0;
        out_share1    = (state_q == DONE) ? sh1_q : '0;
    end
endmodule

// File: doc/masked_chi5_plane_ctrl.md
# masked_chi5_plane_ctrl

Sequencer that runs one 25-bit, two-share Keccak plane through a single shared masked chi5 datapath, one 5-bit row at a time. It accepts a plane over a valid/ready handshake and drives the chi5 share inputs, holding each row stable for a fixed settle window. It gates fresh randomness onto the datapath's 1-bit rand input, then writes each result row back in place and returns the plane over a second valid/ready handshake. It sits between the permutation round controller and the chi5 instance.

## Interface
- LAT, 4: cycles a row is held on the chi5 inputs before its outputs are sampled; must be ≥ 1 and ≥ the chi5 input-to-output depth.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  input plane available
- in_ready  out  1  controller can accept a plane
- in_share0, in_share1  in  25 each  plane shares; row r = bits [5r+4:5r]
- rnd_valid  in  1  fresh random bit available
- rnd_bit  in  1  random bit
- rnd_ready  out  1  controller consumes rnd_bit this cycle
- chi_share0_in, chi_share1_in  out  5 each  row shares to chi5
- chi_rand  out  1  rand to chi5
- chi_share0_out, chi_share1_out  in  5 each  row result shares from chi5
- out_valid  in/out: out  1  result plane available
- out_ready  in  1  consumer accepts result
- out_share0, out_share1  out  25 each  result plane shares
- busy  out  1  high in RUN or DONE

## Operation
- Storage: two 25-bit plane registers (sh0, sh1), used both as the input buffer and the result buffer. Row counter row (0..4). Hold counter cnt (0..LAT-1).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load sh0/sh1 from the inputs, set row=0 and cnt=0, go to RUN.
- RUN:
  - chi_shareX_in = shX[5row+4:5row].
  - rnd_ready=1.
  - chi_rand = rnd_bit & rnd_valid.
  - If rnd_valid=0: set cnt←0. The row restarts its window, because a row completes only after LAT consecutive cycles with valid randomness.
  - If rnd_valid=1 and cnt<LAT-1: cnt←cnt+1.
  - If rnd_valid=1 and cnt==LAT-1: write shX[5row+4:5row]←chi_shareX_out and set cnt←0.
    - If row==4, go to DONE.
    - Otherwise row←row+1.
- DONE:
  - out_valid=1; out_shareX=shX.
  - On out_ready: go to IDLE.
  - Data stays stable while out_valid=1 and out_ready=0.
- Outside RUN: chi_share0_in, chi_share1_in, chi_rand and rnd_ready are all 0. Unmasked values never appear on the datapath.
- The two shares are never combined inside the block. No logic may XOR sh0 with sh1.
- in_valid is ignored outside IDLE (in_ready=0). out_ready is ignored outside DONE.

## Timing
- Reset values:
  - State IDLE, row=0, cnt=0, sh0=sh1=0.
  - in_ready=1; out_valid=0; busy=0; rnd_ready=0.
  - All chi_* outputs 0; out_share0=out_share1=0.
- Reset is asynchronous at any point, including mid-RUN or in DONE. It aborts the plane, drops out_valid immediately, and discards partial results.
- Latency: accept in cycle 0 → RUN row 0 in cycles 1..LAT → out_valid in cycle 5·LAT+1, provided rnd_valid stays high.
- Each rnd_valid=0 cycle in RUN adds (cycles already counted in the current row + 1).
- Throughput: one plane per 5·LAT+2 cycles with out_ready tied high, since DONE→IDLE→accept costs one cycle each.
- Results are sampled at the clock edge that ends the last hold cycle. The row inputs change only on the following cycle.

## Test plan
- Stub datapath (output = input with share0 XOR 5'h1F, combinational), LAT=4, rnd_valid=1, in_share0=25'h0AAAAAA, in_share1=0:
  - out_valid rises exactly at cycle 21.
  - out_share0 = 25'h1555555, out_share1 = 0.
- Real chi5, LAT=4:
  - Plane shares sh0=25'h1ABCDEF, sh1=25'h1ABCDEF (unmasked plane 0) → out_share0 ^ out_share1 = 0.
  - Unmasked plane 25'h1FFFFFF (sh0=25'h0123456, sh1=sh0^25'h1FFFFFF) → out_share0 ^ out_share1 = 25'h1FFFFFF.
- Stub datapath: drop rnd_valid for 1 cycle at cnt=2 of row 1 → completion delayed by exactly 3 cycles (out_valid at cycle 24).
  - During the dropped cycle, chi_rand=0 and the row inputs are unchanged.
- Hold out_ready=0 for 10 cycles in DONE:
  - out_valid and out data stay stable.
  - in_ready=0 and in_valid is ignored.
  - out_ready=1 → IDLE next cycle and a new plane is accepted the cycle after.
- Assert rst_n=0 asynchronously mid-row 2:
  - All outputs return to their reset values without waiting for a clock edge.
  - After release, a new plane completes correctly at 5·LAT+1 cycles.
